alu_pipe: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshake on input and output, status flags,
//  and an optional iterative shift-add multiplier. Sits between the decode/register-read stage
//  and writeback of the RISC datapath, replacing the purely combinational ALU.

---
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 tb/tb_alu_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides, status flags and an
// optional iterative shift-add multiplier that back-pressures the input while it runs.
module alu_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_NOT, OP_SHL, OP_SHR, OP_AND,
    OP_OR, OP_SLTU, OP_SLT, OP_XOR, OP_SRA, OP_MUL
  } alu_op_t;

  state_t             r_state, w_state_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero, r_carry, r_ovf, r_neg;
  logic [2*WIDTH-1:0] r_mcand, r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_add, w_sub;
  logic               w_add_ovf, w_sub_ovf, w_lts, w_big;
  logic [CW-1:0]      w_shamt;
  logic [WIDTH-1:0]   w_alu_res, w_ld_res;
  logic               w_alu_carry, w_alu_ovf, w_ld_carry, w_ld_ovf;
  logic               w_out_free, w_is_mul, w_load, w_mul_start, w_mul_step;

  assign w_add     = {1'b0, src_a} + {1'b0, src_b};
  assign w_sub     = {1'b0, src_a} - {1'b0, src_b};
  assign w_add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_add[WIDTH-1] != src_a[WIDTH-1]);
  assign w_sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_sub[WIDTH-1] != src_a[WIDTH-1]);
  assign w_lts     = $signed(src_a) < $signed(src_b);
  // WIDTH is a power of two, so any set bit above the index field means amount >= WIDTH
  assign w_big     = |src_b[WIDTH-1:CW];
  assign w_shamt   = src_b[CW-1:0];

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    case (op)
      OP_SUB:  begin
        w_alu_res   = w_sub[WIDTH-1:0];
        w_alu_carry = w_sub[WIDTH];
        w_alu_ovf   = w_sub_ovf;
      end
      OP_NOT:  w_alu_res = ~src_a;
      OP_SHL:  w_alu_res = w_big ? '0 : (src_a << w_shamt);
      OP_SHR:  w_alu_res = w_big ? '0 : (src_a >> w_shamt);
      OP_AND:  w_alu_res = src_a & src_b;
      OP_OR:   w_alu_res = src_a | src_b;
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lts};
      OP_XOR:  w_alu_res = src_a ^ src_b;
      OP_SRA:  w_alu_res = w_big ? {WIDTH{src_a[WIDTH-1]}} : ($signed(src_a) >>> w_shamt);
      default: begin
        w_alu_res   = w_add[WIDTH-1:0];
        w_alu_carry = w_add[WIDTH];
        w_alu_ovf   = w_add_ovf;
      end
    endcase
  end

  assign w_out_free = ~r_out_valid | out_ready;
  assign w_is_mul   = MUL_EN && (op == OP_MUL);
  assign in_ready   = rst_n && (r_state == S_IDLE) && w_out_free;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_mul_start = 1'b0;
    w_mul_step  = 1'b0;
    w_ld_res    = w_alu_res;
    w_ld_carry  = w_alu_carry;
    w_ld_ovf    = w_alu_ovf;
    case (r_state)
      S_IDLE: if (in_valid && in_ready) begin
        if (w_is_mul) begin
          w_state_nxt = S_MUL;
          w_mul_start = 1'b1;
        end else begin
          w_load = 1'b1;
        end
      end
      S_MUL: begin
        w_mul_step = 1'b1;
        if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_ld_res   = r_acc[WIDTH-1:0];
        w_ld_carry = |r_acc[2*WIDTH-1:WIDTH];
        w_ld_ovf   = 1'b0;
        if (w_out_free) begin
          w_load      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_ld_res;
        r_zero      <= (w_ld_res == '0);
        r_carry     <= w_ld_carry;
        r_ovf       <= w_ld_ovf;
        r_neg       <= w_ld_res[WIDTH-1];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Full 2*WIDTH product is kept so the high half can drive the carry flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mul_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, src_a};
      r_mplier <= src_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_mul_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign negative  = r_neg;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results on accept, monitor
// compares every presented output and pops on transfer.
module tb_alu_pipe;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b, result;
  logic         zero, carry, overflow, negative, busy;

  logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [3:0]   n_op;
  logic [W-1:0] n_a, n_b, n_result;
  logic         n_zero, n_carry, n_overflow, n_negative, n_busy;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;
  logic [W+3:0] q[$];

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .negative(negative), .busy(busy)
  );

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) u_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op),
    .src_a(n_a), .src_b(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_result), .zero(n_zero), .carry(n_carry), .overflow(n_overflow),
    .negative(n_negative), .busy(n_busy)
  );

  function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input bit mul_en);
    longint m    = longint'(1) << W;
    longint half = m / 2;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint sa   = (ua >= half) ? ua - m : ua;
    longint sb   = (ub >= half) ? ub - m : ub;
    longint r    = 0;
    int     amt  = (ub >= longint'(W)) ? int'(W) - 1 : int'(ub);
    int     eo   = (o >= 4'd12 || (o == 4'd11 && !mul_en)) ? 0 : int'(o);
    logic   c    = 1'b0;
    logic   v    = 1'b0;
    logic [W-1:0] res;
    case (eo)
      0:  begin r = ua + ub; c = (r >= m); v = (sa + sb >= half) || (sa + sb < -half); end
      1:  begin r = ua - ub; c = (ua < ub); v = (sa - sb >= half) || (sa - sb < -half); end
      2:  r = m - 1 - ua;
      3:  r = (ub >= longint'(W)) ? 0 : ua * (longint'(1) << amt);
      4:  r = (ub >= longint'(W)) ? 0 : ua / (longint'(1) << amt);
      5:  r = ua & ub;
      6:  r = ua | ub;
      7:  r = (ua < ub) ? 1 : 0;
      8:  r = (sa < sb) ? 1 : 0;
      9:  r = ua ^ ub;
      10: r = sa >>> amt;
      11: begin r = ua * ub; c = (r >= m); end
      default: r = 0;
    endcase
    res = r[W-1:0];
    return {res, (res == '0), c, v, res[W-1]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, op %0h", n, o);
    end else begin
      q.push_back(model(o, a, b, 1'b1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, out_valid %0b", q.size(), out_valid);
    end
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(1));
        1:       out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output: result 0x%0h with nothing expected", result);
        end else begin
          chk("result_flags", {result, zero, carry, overflow, negative}, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   d_op [6] = '{4'h1, 4'h8, 4'h7, 4'h3, 4'hA, 4'h4};
    logic [W-1:0] d_a  [6] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000};
    logic [W-1:0] d_b  [6] = '{16'h0001, 16'h0001, 16'h0001, 16'd16, 16'd20, 16'd15};
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
    n_in_valid = 1'b0; n_op = '0; n_a = '0; n_b = '0; n_out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, carry, overflow, negative}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    rdy_mode = 1;
    issue(4'h0, 16'hFFFF, 16'h0001);
    chk("add_latency_valid", out_valid, 1);
    wait_drain();

    for (int i = 0; i < 6; i++) issue(d_op[i], d_a[i], d_b[i]);
    wait_drain();

    issue(4'hB, 16'h0100, 16'h0100);
    chk("mul_busy", busy, 1);
    n = 0;
    do begin
      @(negedge clk); #1;
      if (!in_ready) n++;
    end while (!in_ready && n < 100);
    chk("mul_stall_cycles", n, 17);
    chk("mul_busy_done", busy, 0);
    wait_drain();

    rdy_mode = 2;
    for (int i = 0; i < 8; i++) issue(4'h0, W'($urandom), W'($urandom));
    rdy_mode = 1;
    wait_drain();

    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      issue(4'($urandom_range(15)), W'($urandom), ($urandom_range(3) == 0) ? W'($urandom_range(20)) : W'($urandom));
    end
    rdy_mode = 1;
    wait_drain();

    issue(4'hB, W'($urandom), W'($urandom));
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_rst_out_valid", out_valid, 0);
    chk("midmul_rst_busy", busy, 0);
    chk("midmul_rst_in_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h0, 16'h0002, 16'h0003);
    wait_drain();

    @(negedge clk);
    n_op = 4'hB; n_a = 16'h0100; n_b = 16'h0100; n_in_valid = 1'b1;
    #1;
    chk("nomul_in_ready", n_in_ready, 1);
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    chk("nomul_out_valid", n_out_valid, 1);
    chk("nomul_busy", n_busy, 0);
    chk("nomul_result_flags", {n_result, n_zero, n_carry, n_overflow, n_negative},
        model(4'hB, 16'h0100, 16'h0100, 1'b0));

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
